bitwise_logic_unit: RTL and testbench

- Parametrised, registered successor to the fixed 16-bit combinational AND.
- Accepts two WIDTH-bit operands and a 3-bit opcode over a valid/ready handshake.
- Computes one of eight bitwise functions and returns the result, plus zero/all-ones flags, through a one-deep output register with backpressure.
- Supports chained operation, where the previous result replaces operand A, so the ALU can reduce multi-word masks without an external accumulator.

---
 rtl/bitwise_logic_unit.sv | 81 ++++++++
 tb/tb_bitwise_logic_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bitwise_logic_unit.sv
// rtl/bitwise_logic_unit.sv - registered WIDTH-bit bitwise ALU with chaining and a one-deep output register
// Optional BLU_PARITY_EN adds out_parity, the XOR-reduction of the registered result.
module bitwise_logic_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
`ifdef BLU_PARITY_EN
    output logic             out_parity,
`endif
    output logic             out_ones
);

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ANDN = 3'b110;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result;
    logic             accept;

    // Draining the output register this cycle frees it for a new beat in the same cycle.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign op_a     = in_chain ? acc : in_a;

    always_comb begin
        result = in_b;
        case (in_op)
            OP_AND:  result = op_a & in_b;
            OP_OR:   result = op_a | in_b;
            OP_XOR:  result = op_a ^ in_b;
            OP_NAND: result = ~(op_a & in_b);
            OP_NOR:  result = ~(op_a | in_b);
            OP_XNOR: result = ~(op_a ^ in_b);
            OP_ANDN: result = op_a & ~in_b;
            default: result = in_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b1;
            out_ones   <= 1'b0;
            acc        <= '1;
`ifdef BLU_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_result <= result;
            out_zero   <= (result == '0);
            out_ones   <= (result == '1);
            acc        <= result;
`ifdef BLU_PARITY_EN
            out_parity <= ^result;
`endif
        end else if (out_ready) begin
            // Result and flags hold their last value once consumed.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bitwise_logic_unit.sv
// tb/tb_bitwise_logic_unit.sv - directed self-checking bench for bitwise_logic_unit
module tb_bitwise_logic_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [2:0]  in_op;
    logic        in_chain;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic        out_zero;
    logic        out_ones;
`ifdef BLU_PARITY_EN
    logic        out_parity;
`endif

    int tests_run;
    int tests_failed;

    bitwise_logic_unit #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .in_chain   (in_chain),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
`ifdef BLU_PARITY_EN
        .out_parity (out_parity),
`endif
        .out_ones   (out_ones)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic ch, input logic [15:0] a,
                         input logic [15:0] b, input logic [2:0] op);
        in_valid = v;
        in_chain = ch;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 3'b000);
        out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", out_valid); end
        tests_run++; if (out_result !== 16'h0000) begin tests_failed++; $display("FAIL reset_result got %h want 0000", out_result); end
        tests_run++; if (out_zero !== 1'b1) begin tests_failed++; $display("FAIL reset_zero got %b want 1", out_zero); end
        tests_run++; if (out_ones !== 1'b0) begin tests_failed++; $display("FAIL reset_ones got %b want 0", out_ones); end
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef BLU_PARITY_EN
        tests_run++; if (out_parity !== 1'b0) begin tests_failed++; $display("FAIL reset_parity got %b want 0", out_parity); end
`endif
    endtask

    task automatic test_and();
        drive(1'b1, 1'b0, 16'hF0F0, 16'h3C3C, 3'b000);
        tick();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 3'b000);
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL and_valid got %b want 1", out_valid); end
        tests_run++; if (out_result !== 16'h3030) begin tests_failed++; $display("FAIL and_result got %h want 3030", out_result); end
        tests_run++; if (out_zero !== 1'b0 || out_ones !== 1'b0) begin tests_failed++; $display("FAIL and_flags got z=%b o=%b want z=0 o=0", out_zero, out_ones); end
        tick();
        tests_run++; if (out_valid !== 1'b0 || out_result !== 16'h3030) begin tests_failed++; $display("FAIL and_drain got v=%b r=%h want v=0 r=3030", out_valid, out_result); end
    endtask

    task automatic test_all_opcodes();
        logic [15:0] expected [8];
        expected = '{16'h0AA0, 16'hAFFA, 16'hA55A, 16'hF55F,
                     16'h5005, 16'h5AA5, 16'hA00A, 16'h0FF0};
        // Back-to-back: one beat per cycle with out_ready held high.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 16'hAAAA, 16'h0FF0, 3'(i));
            tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL op%0d_in_ready got %b want 1", i, in_ready); end
            tick();
            tests_run++; if (out_valid !== 1'b1 || out_result !== expected[i]) begin tests_failed++; $display("FAIL op%0d_result got v=%b r=%h want v=1 r=%h", i, out_valid, out_result, expected[i]); end
            if (i == 5) begin
                tests_run++; if (out_ones !== 1'b0) begin tests_failed++; $display("FAIL xnor_ones got %b want 0", out_ones); end
            end
        end
        drive(1'b1, 1'b0, 16'hFF00, 16'h00FF, 3'b001);
        tick();
        tests_run++; if (out_ones !== 1'b1 || out_zero !== 1'b0 || out_result !== 16'hFFFF) begin tests_failed++; $display("FAIL or_all_ones got r=%h o=%b z=%b want r=ffff o=1 z=0", out_result, out_ones, out_zero); end
        drive(1'b0, 1'b0, 16'h0, 16'h0, 3'b000);
        tick();
    endtask

    task automatic test_chain();
        logic [15:0] b_vals [4];
        logic [2:0]  ops    [4];
        logic [15:0] expected [4];
        b_vals   = '{16'hFF00, 16'h0FF0, 16'h00FF, 16'h0FFF};
        ops      = '{3'b000, 3'b000, 3'b010, 3'b010};
        expected = '{16'hFF00, 16'h0F00, 16'h0FFF, 16'h0000};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 16'h5555, b_vals[i], ops[i]);
            tick();
            tests_run++; if (out_valid !== 1'b1 || out_result !== expected[i]) begin tests_failed++; $display("FAIL chain%0d_result got v=%b r=%h want v=1 r=%h", i, out_valid, out_result, expected[i]); end
        end
        tests_run++; if (out_zero !== 1'b1) begin tests_failed++; $display("FAIL chain_zero got %b want 1", out_zero); end
        drive(1'b0, 1'b0, 16'h0, 16'h0, 3'b000);
        tick();
    endtask

    task automatic test_backpressure();
        drive(1'b1, 1'b0, 16'hFFFF, 16'h1234, 3'b000);
        out_ready = 1'b0;
        tick();
        tests_run++; if (out_valid !== 1'b1 || out_result !== 16'h1234) begin tests_failed++; $display("FAIL bp_load got v=%b r=%h want v=1 r=1234", out_valid, out_result); end
        drive(1'b1, 1'b1, 16'h0000, 16'h00FF, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_in_ready%0d got %b want 0", i, in_ready); end
            tick();
            tests_run++; if (out_result !== 16'h1234 || out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_hold%0d got v=%b r=%h want v=1 r=1234", i, out_valid, out_result); end
        end
        out_ready = 1'b1;
        #1;
        tests_run++; if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        tick();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 3'b000);
        // 0034 proves acc stayed 1234 through the stall.
        tests_run++; if (out_valid !== 1'b1 || out_result !== 16'h0034) begin tests_failed++; $display("FAIL bp_release_result got v=%b r=%h want v=1 r=0034", out_valid, out_result); end
        tick();
        tests_run++; if (out_valid !== 1'b0 || out_result !== 16'h0034) begin tests_failed++; $display("FAIL bp_no_dup got v=%b r=%h want v=0 r=0034", out_valid, out_result); end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 1'b0, 16'hAAAA, 16'h5555, 3'b001);
        out_ready = 1'b0;
        tick();
        tests_run++; if (out_valid !== 1'b1 || out_result !== 16'hFFFF) begin tests_failed++; $display("FAIL mid_full got v=%b r=%h want v=1 r=ffff", out_valid, out_result); end
        out_ready = 1'b1;
        drive(1'b1, 1'b0, 16'h1111, 16'h2222, 3'b001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 16'h0, 3'b000);
        tests_run++; if (out_valid !== 1'b0 || out_result !== 16'h0000 || out_zero !== 1'b1) begin tests_failed++; $display("FAIL mid_reset got v=%b r=%h z=%b want v=0 r=0000 z=1", out_valid, out_result, out_zero); end
        drive(1'b1, 1'b1, 16'h0000, 16'h1234, 3'b000);
        tick();
        drive(1'b0, 1'b0, 16'h0, 16'h0, 3'b000);
        tests_run++; if (out_valid !== 1'b1 || out_result !== 16'h1234) begin tests_failed++; $display("FAIL mid_chain got v=%b r=%h want v=1 r=1234", out_valid, out_result); end
        tick();
    endtask

`ifdef BLU_PARITY_EN
    task automatic test_parity();
        drive(1'b1, 1'b0, 16'h0001, 16'h0002, 3'b001);
        tick();
        tests_run++; if (out_result !== 16'h0003 || out_parity !== 1'b0) begin tests_failed++; $display("FAIL parity_or got r=%h p=%b want r=0003 p=0", out_result, out_parity); end
        drive(1'b1, 1'b0, 16'h0000, 16'h0007, 3'b111);
        tick();
        tests_run++; if (out_result !== 16'h0007 || out_parity !== 1'b1) begin tests_failed++; $display("FAIL parity_pass got r=%h p=%b want r=0007 p=1", out_result, out_parity); end
        drive(1'b0, 1'b0, 16'h0, 16'h0, 3'b000);
        tick();
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        in_chain  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        test_reset();
        test_and();
        test_all_opcodes();
        test_chain();
        test_backpressure();
        test_reset_midstream();
`ifdef BLU_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
